mbox_nxm_era: RTL and testbench
===============================

MBOX_NXM_ERA -- requirements
Module: mbox_nxm_era

Interface
REQ-001 Parameter NSRC, default 2: number of memory request sources (EBOX, channels, CCA); range 1..8.
REQ-002 Parameter TMO_W, default 8: width of the NXM timeout counter.
REQ-003 Parameter ADR_W, default 22: physical address width (PMA 14:35).
REQ-004 clk  in  1  MBOX clock; all state changes on its rising edge.
REQ-005 RESET  in  1  reset, synchronous, active-high.
REQ-006 MEM_START  in  1  one-cycle pulse that starts a memory cycle.
REQ-007 SRC  in  $clog2(NSRC) (min 1)  requesting source; sampled with MEM_START.
REQ-008 ADR  in  ADR_W  physical address; sampled with MEM_START.
REQ-009 MEM_RD_RQ  in  1  read request; sampled with MEM_START.
REQ-010 ACKN_PULSE  in  1  memory acknowledge pulse.
REQ-011 TMO_LIMIT  in  TMO_W  timeout in cycles; 0 disables the timeout.
REQ-012 NXM_ERR_CLR  in  NSRC  per-source clear of the sticky NXM error.
REQ-013 ERA_CLR  in  1  releases the error address register.
REQ-014 EXT_ERR_HOLD  in  1  another error (parity, SBUS) already owns the ERA.
REQ-015 MEM_BUSY  out  1  cycle in progress.
REQ-016 NXM_ACK  out  1  synthetic acknowledge pulse.
REQ-017 NXM_DATA_VAL  out  1  synthetic read-data-valid pulse.
REQ-018 NXM_ERR  out  NSRC  sticky per-source NXM error.
REQ-019 NXM_ANY  out  1  NXM sequence active.
REQ-020 ERA_VALID, ERA_ADR[ADR_W], ERA_SRC, ERA_WRITE  out  captured error address, source and direction.
REQ-021 START_ERR  out  1  sticky protocol error: MEM_START received while busy.

Function
REQ-022 States: IDLE, WAIT, NXM (5 sub-cycles T2..T6). MEM_BUSY SHALL be 1 in WAIT and NXM.
REQ-023 IDLE + MEM_START -> WAIT on the next edge. SRC, ADR and ~MEM_RD_RQ are latched. The counter is cleared.
REQ-024 In WAIT the counter SHALL increment by 1 each cycle and saturate at all-ones.
REQ-025 WAIT + ACKN_PULSE -> IDLE. ACKN_PULSE SHALL take priority over a timeout in the same cycle.
REQ-026 WAIT, with TMO_LIMIT != 0, counter == TMO_LIMIT-1 and no ACKN_PULSE -> NXM. First NXM cycle (T2) SHALL occur exactly TMO_LIMIT cycles after the WAIT entry edge.
REQ-027 NXM SHALL run exactly T2,T3,T4,T5,T6, then return to IDLE. A late ACKN_PULSE during NXM SHALL be ignored.
REQ-028 NXM_ACK SHALL be 1 only in T2. NXM_ANY SHALL be 1 during T2..T6.
REQ-029 NXM_DATA_VAL SHALL be 1 in T6 only if the latched request was a read.
REQ-030 At T2, NXM_ERR[latched SRC] SHALL set. If NXM_ERR_CLR for the same bit is asserted in that cycle, set SHALL win.
REQ-031 NXM_ERR_CLR[i] SHALL clear bit i in any other cycle; other bits SHALL be unaffected.
REQ-032 At T2, the ERA SHALL load latched ADR/SRC/write and set ERA_VALID, only if ERA_VALID=0 and EXT_ERR_HOLD=0 (first error wins).
REQ-033 ERA_CLR SHALL clear ERA_VALID. If ERA_CLR coincides with T2 capture, capture SHALL win.
REQ-034 MEM_START in WAIT or NXM SHALL be ignored for sequencing and SHALL set START_ERR; START_ERR clears only on RESET.
REQ-035 MEM_START in the same cycle the FSM returns to IDLE SHALL be ignored and SHALL set START_ERR.
REQ-036 A TMO_LIMIT change during WAIT SHALL take effect in the next compare cycle.

Reset
REQ-037 RESET SHALL force IDLE and clear the counter, NXM_ERR, ERA_VALID, ERA_ADR, ERA_SRC, ERA_WRITE and START_ERR. This SHALL apply mid-WAIT or mid-NXM, with no NXM_ACK or NXM_DATA_VAL emitted afterward.
REQ-038 All outputs SHALL be 0 in the cycle after RESET is sampled.

Structure
REQ-039 The FSM state enum and the default parameter constants SHALL live in the shared ebox package header.
REQ-040 The timeout counter SHALL be one sub-module, nxm_tmo_ctr: clear, enable, saturate, compare-to-limit output.
REQ-041 No other sub-modules; the ERA SHALL be a plain register in this block.

Verification
REQ-042 TMO_LIMIT=8; read start, SRC=1, ADR=0x12345; no ACKN. Required: NXM_ACK at cycle 8; NXM_DATA_VAL at cycle 12; NXM_ERR=2'b10; ERA_ADR=0x12345; ERA_SRC=1; ERA_WRITE=0.
REQ-043 TMO_LIMIT=8; ACKN_PULSE at cycle 8, coincident with the limit. Required: return to IDLE; no NXM_ACK; NXM_ERR unchanged.
REQ-044 Two NXM timeouts: SRC 0, then SRC 1, with no ERA_CLR between. Required: ERA holds the SRC-0 address; NXM_ERR=2'b11.
REQ-045 NXM_ERR_CLR[0] asserted in the T2 of a SRC-0 timeout. Required: NXM_ERR[0]=1. Repeat the clear in a later cycle. Required: NXM_ERR[0]=0.
REQ-046 RESET asserted at T4. Required: IDLE next cycle; no NXM_DATA_VAL; all outputs 0.
REQ-047 MEM_START while in WAIT. Required: START_ERR=1; original timeout unaffected. Also TMO_LIMIT=0 with no ACKN for 300 cycles. Required: MEM_BUSY stays 1; no NXM.

Source files
------------

// File: rtl/mbox_nxm_era_pkg.sv
// ---- mbox_nxm_era_pkg : shared FSM encoding and default sizing (rev 1.0) ----
`default_nettype none

package mbox_nxm_era_pkg;

  localparam int NSRC_DEF  = 2;
  localparam int TMO_W_DEF = 8;
  localparam int ADR_W_DEF = 22;

  // NXM sequence unrolled into one state per sub-cycle T2..T6
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6
  } nxm_state_e;

endpackage

`default_nettype wire

// File: rtl/mbox_nxm_era_tmo_ctr.sv
// ---- mbox_nxm_era_tmo_ctr : saturating NXM timeout counter (rev 1.0) ----
`default_nettype none

module mbox_nxm_era_tmo_ctr #(
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [TMO_W-1:0] limit_i,
  output logic             hit_o
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare against limit-1 so the transition edge lands limit cycles after entry
  assign hit_o = (limit_i != '0) && (cnt_q == (limit_i - TMO_W'(1)));

endmodule

`default_nettype wire

// File: rtl/mbox_nxm_era.sv
// ---- mbox_nxm_era : memory-cycle NXM timeout sequencer with error address register (rev 1.0) ----
`default_nettype none

module mbox_nxm_era
  import mbox_nxm_era_pkg::*;
#(
  parameter int  NSRC  = NSRC_DEF,
  parameter int  TMO_W = TMO_W_DEF,
  parameter int  ADR_W = ADR_W_DEF,
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             mem_start_i,
  input  logic [SRC_W-1:0] src_i,
  input  logic [ADR_W-1:0] adr_i,
  input  logic             mem_rd_rq_i,
  input  logic             ackn_pulse_i,
  input  logic [TMO_W-1:0] tmo_limit_i,
  input  logic [NSRC-1:0]  nxm_err_clr_i,
  input  logic             era_clr_i,
  input  logic             ext_err_hold_i,
  output logic             mem_busy_o,
  output logic             nxm_ack_o,
  output logic             nxm_data_val_o,
  output logic [NSRC-1:0]  nxm_err_o,
  output logic             nxm_any_o,
  output logic             era_valid_o,
  output logic [ADR_W-1:0] era_adr_o,
  output logic [SRC_W-1:0] era_src_o,
  output logic             era_write_o,
  output logic             start_err_o
);

  nxm_state_e       state_q, state_d;
  logic             tmo_clr, tmo_en, tmo_hit;
  logic [SRC_W-1:0] src_q;
  logic [ADR_W-1:0] adr_q;
  logic             wr_q;
  logic [NSRC-1:0]  nxm_err_q, nxm_err_d, nxm_set;
  logic             era_valid_q, era_write_q, era_load;
  logic [ADR_W-1:0] era_adr_q;
  logic [SRC_W-1:0] era_src_q;
  logic             start_err_q;
  logic             in_t2;

  mbox_nxm_era_tmo_ctr #(
    .TMO_W (TMO_W)
  ) u_tmo_ctr (
    .clk     (clk),
    .reset_i (reset_i),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .limit_i (tmo_limit_i),
    .hit_o   (tmo_hit)
  );

  always_comb begin
    state_d = state_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_start_i) begin
          state_d = ST_WAIT;
          tmo_clr = 1'b1;
        end
      end
      ST_WAIT: begin
        tmo_en = 1'b1;
        // Acknowledge beats a timeout landing in the same cycle
        if (ackn_pulse_i) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_T2;
        end
      end
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = ST_T6;
      ST_T6:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_t2    = (state_q == ST_T2);
  // Out-of-range sources shift past the top bit and set nothing
  assign nxm_set  = in_t2 ? (NSRC'(1) << src_q) : '0;
  assign nxm_err_d = (nxm_err_q & ~nxm_err_clr_i) | nxm_set;
  assign era_load = in_t2 && !era_valid_q && !ext_err_hold_i;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      adr_q       <= '0;
      wr_q        <= 1'b0;
      nxm_err_q   <= '0;
      era_valid_q <= 1'b0;
      era_adr_q   <= '0;
      era_src_q   <= '0;
      era_write_q <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nxm_err_q <= nxm_err_d;
      if ((state_q == ST_IDLE) && mem_start_i) begin
        src_q <= src_i;
        adr_q <= adr_i;
        wr_q  <= ~mem_rd_rq_i;
      end
      if ((state_q != ST_IDLE) && mem_start_i) begin
        start_err_q <= 1'b1;
      end
      if (era_load) begin
        era_valid_q <= 1'b1;
        era_adr_q   <= adr_q;
        era_src_q   <= src_q;
        era_write_q <= wr_q;
      end else if (era_clr_i) begin
        era_valid_q <= 1'b0;
      end
    end
  end

  assign mem_busy_o     = (state_q != ST_IDLE);
  assign nxm_ack_o      = in_t2;
  assign nxm_any_o      = (state_q == ST_T2) || (state_q == ST_T3) || (state_q == ST_T4) ||
                          (state_q == ST_T5) || (state_q == ST_T6);
  assign nxm_data_val_o = (state_q == ST_T6) && !wr_q;
  assign nxm_err_o      = nxm_err_q;
  assign era_valid_o    = era_valid_q;
  assign era_adr_o      = era_adr_q;
  assign era_src_o      = era_src_q;
  assign era_write_o    = era_write_q;
  assign start_err_o    = start_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mbox_nxm_era.sv
// ---- tb_mbox_nxm_era : directed checks of NXM sequencing and ERA capture (rev 1.0) ----
`default_nettype none

module tb_mbox_nxm_era;

  logic        clk;
  logic        reset_i;
  logic        mem_start_i;
  logic [0:0]  src_i;
  logic [21:0] adr_i;
  logic        mem_rd_rq_i;
  logic        ackn_pulse_i;
  logic [7:0]  tmo_limit_i;
  logic [1:0]  nxm_err_clr_i;
  logic        era_clr_i;
  logic        ext_err_hold_i;
  logic        mem_busy_o;
  logic        nxm_ack_o;
  logic        nxm_data_val_o;
  logic [1:0]  nxm_err_o;
  logic        nxm_any_o;
  logic        era_valid_o;
  logic [21:0] era_adr_o;
  logic [0:0]  era_src_o;
  logic        era_write_o;
  logic        start_err_o;

  int total = 0;
  int bad   = 0;

  mbox_nxm_era dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .mem_start_i    (mem_start_i),
    .src_i          (src_i),
    .adr_i          (adr_i),
    .mem_rd_rq_i    (mem_rd_rq_i),
    .ackn_pulse_i   (ackn_pulse_i),
    .tmo_limit_i    (tmo_limit_i),
    .nxm_err_clr_i  (nxm_err_clr_i),
    .era_clr_i      (era_clr_i),
    .ext_err_hold_i (ext_err_hold_i),
    .mem_busy_o     (mem_busy_o),
    .nxm_ack_o      (nxm_ack_o),
    .nxm_data_val_o (nxm_data_val_o),
    .nxm_err_o      (nxm_err_o),
    .nxm_any_o      (nxm_any_o),
    .era_valid_o    (era_valid_o),
    .era_adr_o      (era_adr_o),
    .era_src_o      (era_src_o),
    .era_write_o    (era_write_o),
    .start_err_o    (start_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {mem_busy_o, nxm_ack_o, nxm_data_val_o, nxm_err_o, nxm_any_o, era_valid_o,
            era_adr_o, era_src_o, era_write_o, start_err_o};
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  task automatic start(input logic s, input logic [21:0] a, input logic rd);
    mem_start_i = 1'b1;
    src_i       = s;
    adr_i       = a;
    mem_rd_rq_i = rd;
    step();
    mem_start_i = 1'b0;
  endtask

  // Returns cycles waited after the call point until NXM_ACK is seen
  task automatic wait_ack(output int n);
    n = 0;
    while (!nxm_ack_o && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mem_busy_o && n < 400) begin
      step();
      n++;
    end
    chk("idle_bound", 32'(mem_busy_o), 32'd0);
  endtask

  initial begin
    int n;
    int m;
    int seen;
    reset_i = 1'b0; mem_start_i = 1'b0; src_i = '0; adr_i = '0; mem_rd_rq_i = 1'b0;
    ackn_pulse_i = 1'b0; tmo_limit_i = 8'd8; nxm_err_clr_i = '0; era_clr_i = 1'b0;
    ext_err_hold_i = 1'b0;
    step();
    do_reset();
    chk("reset_outs", all_outs(), 32'd0);

    // Read timeout, SRC=1: T2 at 8, T6 at 12
    start(1'b1, 22'h12345, 1'b1);
    chk("busy_wait", 32'(mem_busy_o), 32'd1);
    wait_ack(n);
    chk("ack_latency", 32'(n), 32'd8);
    chk("any_t2", 32'(nxm_any_o), 32'd1);
    m = 0;
    while (!nxm_data_val_o && m < 20) begin
      step();
      m++;
    end
    chk("dval_latency", 32'(n + m), 32'd12);
    step();
    chk("idle_after_t6", 32'({mem_busy_o, nxm_any_o, nxm_data_val_o}), 32'd0);
    chk("nxm_err_src1", 32'(nxm_err_o), 32'b10);
    chk("era_adr", 32'(era_adr_o), 32'h12345);
    chk("era_src", 32'(era_src_o), 32'd1);
    chk("era_write_rd", 32'(era_write_o), 32'd0);
    chk("era_valid", 32'(era_valid_o), 32'd1);
    era_clr_i = 1'b1;
    step();
    era_clr_i = 1'b0;
    chk("era_clr", 32'(era_valid_o), 32'd0);

    // Ack coincident with the limit compare cycle
    do_reset();
    start(1'b0, 22'h00100, 1'b1);
    repeat (7) step();
    ackn_pulse_i = 1'b1;
    step();
    ackn_pulse_i = 1'b0;
    chk("ack_wins_idle", 32'(mem_busy_o), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (nxm_ack_o || nxm_any_o) seen++;
      step();
    end
    chk("ack_wins_no_nxm", 32'(seen), 32'd0);
    chk("ack_wins_err", 32'(nxm_err_o), 32'b00);

    // Two timeouts: first error owns the ERA
    do_reset();
    tmo_limit_i = 8'd4;
    start(1'b0, 22'h0ABCD, 1'b0);
    wait_idle();
    start(1'b1, 22'h3F00F, 1'b1);
    wait_idle();
    chk("two_err_bits", 32'(nxm_err_o), 32'b11);
    chk("two_era_adr", 32'(era_adr_o), 32'h0ABCD);
    chk("two_era_src", 32'(era_src_o), 32'd0);
    chk("two_era_wr", 32'(era_write_o), 32'd1);

    // Clear coincident with T2 loses; later clear wins; ERA held off by external error
    do_reset();
    ext_err_hold_i = 1'b1;
    start(1'b0, 22'h00055, 1'b0);
    wait_ack(n);
    chk("limit4_latency", 32'(n), 32'd4);
    nxm_err_clr_i = 2'b01;
    step();
    nxm_err_clr_i = 2'b00;
    chk("set_beats_clr", 32'(nxm_err_o), 32'b01);
    wait_idle();
    chk("ext_hold_no_era", 32'(era_valid_o), 32'd0);
    ext_err_hold_i = 1'b0;
    nxm_err_clr_i = 2'b01;
    step();
    nxm_err_clr_i = 2'b00;
    chk("later_clr", 32'(nxm_err_o), 32'b00);

    // Reset at T4
    do_reset();
    start(1'b1, 22'h01234, 1'b1);
    wait_ack(n);
    step();
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("rst_t4_outs", all_outs(), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (nxm_ack_o || nxm_data_val_o || mem_busy_o) seen++;
      step();
    end
    chk("rst_t4_quiet", 32'(seen), 32'd0);

    // Start while busy: flagged, original timeout undisturbed
    tmo_limit_i = 8'd8;
    start(1'b0, 22'h00777, 1'b1);
    step();
    step();
    start(1'b1, 22'h3FFFF, 1'b0);
    chk("start_err", 32'(start_err_o), 32'd1);
    wait_ack(m);
    chk("busy_start_lat", 32'(3 + m), 32'd8);
    wait_idle();
    chk("busy_start_err", 32'(nxm_err_o), 32'b01);
    chk("busy_start_era", 32'(era_adr_o), 32'h00777);

    // Timeout disabled
    do_reset();
    chk("start_err_rst", 32'(start_err_o), 32'd0);
    tmo_limit_i = 8'd0;
    start(1'b0, 22'h00001, 1'b1);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (!mem_busy_o || nxm_any_o) seen++;
      step();
    end
    chk("tmo_disabled", 32'(seen), 32'd0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
